// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-detected IRQ lines, priority arbitration with nesting,
// interrupt entry at a safe pipeline boundary and ERET return through an EPC/level stack.
module interrupt_controller #(
   parameter int unsigned   NUM_IRQ     = 3,
   parameter logic [31:0]   VEC_BASE    = 32'h0000_0100,
   parameter logic [31:0]   VEC_STRIDE  = 32'h0000_0040,
   parameter int unsigned   HOLD_CYCLES = 2,
   localparam int unsigned  LVL_W       = $clog2(NUM_IRQ + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               ie_set,
   input  logic               ie_clr,
   input  logic               eret,
   input  logic               stall_in,
   input  logic               id_valid,
   input  logic [31:0]        id_pc,
   input  logic               ex_branch_taken,
   input  logic [31:0]        ex_branch_target,
   output logic               int_take,
   output logic               int_flush,
   output logic [31:0]        int_vector,
   output logic [31:0]        epc_out,
   output logic [LVL_W-1:0]   cur_level,
   output logic [NUM_IRQ-1:0] irq_ack,
   output logic [NUM_IRQ-1:0] pending,
   output logic               global_ie
);

   localparam int unsigned SEL_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
   localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;

   state_t             state;
   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] new_req;
   logic [NUM_IRQ-1:0] elig;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [LVL_W-1:0]   sp;
   logic [31:0]        epc_stk [NUM_IRQ];
   logic [LVL_W-1:0]   lvl_stk [NUM_IRQ];
   logic [SEL_W-1:0]   sel;
   logic [SEL_W-1:0]   top_idx;
   logic [SEL_W-1:0]   push_idx;
   logic               any_elig;
   logic               safe;
   logic               take;
   logic               pop;

   // Arbitration and take decision; take must coincide with the ID instruction it flushes.
   always_comb begin
      new_req = irq & ~irq_q;
      elig    = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         elig[i] = pending[i] & irq_mask[i] & global_ie & (LVL_W'(i + 1) > cur_level);
      end
      any_elig = |elig;
      sel      = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (elig[i]) sel = SEL_W'(i);
      end
      safe     = ~stall_in & ~eret & (id_valid | ex_branch_taken);
      take     = rst_n & (state == ARMED) & any_elig & safe;
      pop      = rst_n & eret & (sp != '0);
      top_idx  = SEL_W'(sp - LVL_W'(1));
      push_idx = SEL_W'(sp);

      int_take   = take;
      int_flush  = take;
      int_vector = take ? (VEC_BASE + 32'(sel) * VEC_STRIDE) : 32'h0;
      irq_ack    = '0;
      if (take) irq_ack[sel] = 1'b1;
      epc_out    = (sp != '0) ? epc_stk[top_idx] : 32'h0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         irq_q     <= '0;
         pending   <= '0;
         global_ie <= 1'b1;
         cur_level <= '0;
         sp        <= '0;
         hold_cnt  <= '0;
         for (int i = 0; i < NUM_IRQ; i++) begin
            epc_stk[i] <= '0;
            lvl_stk[i] <= '0;
         end
      end else begin
         irq_q   <= irq;
         // A fresh edge on a bit being acknowledged stays pending.
         pending <= (pending & ~irq_ack) | new_req;

         if (take)        global_ie <= 1'b0;
         else if (pop)    global_ie <= 1'b1;
         else if (ie_clr) global_ie <= 1'b0;
         else if (ie_set) global_ie <= 1'b1;

         if (take) begin
            epc_stk[push_idx] <= ex_branch_taken ? ex_branch_target : id_pc;
            lvl_stk[push_idx] <= cur_level;
            sp                <= sp + LVL_W'(1);
            cur_level         <= LVL_W'(sel) + LVL_W'(1);
         end else if (pop) begin
            sp        <= sp - LVL_W'(1);
            cur_level <= lvl_stk[top_idx];
         end

         if (take || pop) begin
            state    <= HOLD;
            hold_cnt <= HOLD_W'(HOLD_CYCLES);
         end else begin
            case (state)
               IDLE:  if (any_elig && hold_cnt == '0) state <= ARMED;
               ARMED: if (!any_elig) state <= IDLE;
               HOLD: begin
                  if (hold_cnt <= HOLD_W'(1)) begin
                     hold_cnt <= '0;
                     state    <= IDLE;
                  end else begin
                     hold_cnt <= hold_cnt - HOLD_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Producer side of the pipeline's flush/redirect path; complements the hazard/forwarding unit, which only consumes stall and flush.
- Edge-detects external IRQ lines, latches them as pending, and arbitrates them by priority with nesting.
- Waits for a safe pipeline boundary, then issues a one-cycle interrupt take: flush, vector redirect and EPC push.
- On ERET, pops the saved EPC and restores the previous priority level.

Parameters:
NUM_IRQ, 3, number of interrupt sources; index NUM_IRQ-1 has highest priority
VEC_BASE, 32'h0000_0100, handler address for irq 0
VEC_STRIDE, 32'h0000_0040, address distance between consecutive handler vectors
HOLD_CYCLES, 2, take/ERET guard interval during which no new take is allowed (>=1)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous reset, active low
irq  in  NUM_IRQ  raw device request lines, level, rising edge = new request
irq_mask  in  NUM_IRQ  per-source enable, 1 = enabled
ie_set  in  1  pulse: global interrupt enable set (EI in EX)
ie_clr  in  1  pulse: global interrupt enable clear (DI in EX)
eret  in  1  pulse: ERET instruction in EX
stall_in  in  1  load-use stall from hazard unit
id_valid  in  1  ID stage holds a real (non-bubble) instruction
id_pc  in  32  PC of instruction in ID
ex_branch_taken  in  1  branch/jump resolved taken in EX
ex_branch_target  in  32  target of that branch
int_take  out  1  one-cycle pulse: interrupt entry this cycle
int_flush  out  1  flush IF/ID and ID/EX (asserted with int_take)
int_vector  out  32  redirect PC, valid while int_take=1
epc_out  out  32  top of EPC stack (ERET redirect target); 0 when empty
cur_level  out  clog2(NUM_IRQ+1)  current service level, 0 = none, i+1 = serving irq i
irq_ack  out  NUM_IRQ  one-hot pulse clearing the serviced pending bit
pending  out  NUM_IRQ  latched pending bits (debug/CSR read)
global_ie  out  1  global enable state

Behaviour:
- Reset (rst_n=0 at clk edge): pending=0, irq sync/edge regs=0, global_ie=1, cur_level=0, stack empty (sp=0, entries 0), state=IDLE, hold counter=0, all pulse outputs 0, int_vector=0, epc_out=0.
- Edge detect: irq registered once; new request when irq & ~irq_q. The pending bit sets the cycle after the edge.
  - Set and irq_ack on the same bit in one cycle: set wins.
- Global enable: ie_clr and ie_set in the same cycle → clr wins. global_ie cleared on take; restored to 1 on ERET.
- Eligible i = pending[i] & irq_mask[i] & global_ie & (i+1 > cur_level). sel = highest eligible index.
  - global_ie=0 blocks everything, so nesting happens only if the handler executes EI.
- FSM:
  - IDLE: any eligible and hold counter=0 → ARMED.
  - ARMED: sel recomputed every cycle. No eligible → IDLE.
    - safe = ~stall_in & ~eret & (id_valid | ex_branch_taken).
    - If safe: int_take=int_flush=1; int_vector = VEC_BASE + sel*VEC_STRIDE; irq_ack[sel]=1.
    - Push EPC = ex_branch_taken ? ex_branch_target : id_pc, together with old cur_level.
    - cur_level = sel+1; global_ie=0; hold=HOLD_CYCLES; → HOLD.
  - HOLD: decrement; at 0 → IDLE.
- ERET (any state except during an int_take cycle, which is impossible since safe requires ~eret):
  - stack non-empty: pop; epc_out shows the popped entry combinationally during the eret cycle; cur_level restored next cycle; global_ie=1; hold=HOLD_CYCLES; → HOLD.
  - stack empty: ignored, no state change.
- Stack depth NUM_IRQ. Overflow is impossible because cur_level is strictly increasing.
- The instruction in EX completes. Flushed ID instruction re-executes after ERET.

Test Plan:
- Reset then irq[0] rising, mask=3'b111 → pending[0]=1 next cycle; int_take 1 cycle later with int_vector=0x100, irq_ack=3'b001, epc=id_pc, cur_level=1, global_ie=0.
- irq[0] and irq[2] same edge → take irq 2 first, int_vector=0x180; irq 0 remains pending, taken only after ERET restores cur_level=0.
- In handler of irq 0: ie_set, then irq[1] edge → nested take, vector 0x140, stack holds 2 EPCs. Two ERETs return epc_out in LIFO order, cur_level 2→1→0.
- irq pending while stall_in=1 for 3 cycles → no int_take until stall drops. With ex_branch_taken=1, target=0x2000 → pushed EPC=0x2000.
- eret with empty stack → no change, epc_out=0. ie_set and ie_clr together → global_ie=0.
- rst_n=0 while in ARMED/HOLD with stack depth 1 → all outputs and state back to reset values on that edge; no int_take.
